// File: rtl/psmac_pkg.sv
// Shared types and constants for the precision-scalable MAC datapath.
package psmac_pkg;

   localparam int unsigned ACC_W_DEF   = 32;
   localparam int unsigned MAX_LEN_DEF = 256;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } state_e;

   localparam logic signed [15:0] SAT16_MAX = 16'sh7FFF;
   localparam logic signed [15:0] SAT16_MIN = 16'sh8000;

endpackage

// File: rtl/psmac_requant.sv
// Combinational ReLU, half-up rounding arithmetic shift and saturation to 16 bits.
module psmac_requant
   import psmac_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0] val_i,
   input  logic             relu_en_i,
   input  logic [3:0]       shamt_i,
   output logic [15:0]      q_o
);

   logic signed [ACC_W:0] relu_v;
   logic signed [ACC_W:0] rnd_v;
   logic signed [ACC_W:0] shf_v;
   logic [ACC_W:0]        half_v;

   // One extra bit of headroom keeps the rounding add from wrapping.
   always_comb begin
      relu_v = (relu_en_i && val_i[ACC_W-1]) ? '0 : {val_i[ACC_W-1], val_i};
      half_v = (shamt_i == 4'd0) ? '0 : ((ACC_W+1)'(1) << (shamt_i - 4'd1));
      rnd_v  = relu_v + half_v;
      shf_v  = rnd_v >>> shamt_i;
      if ((shf_v[ACC_W:15] == '0) || (shf_v[ACC_W:15] == '1)) begin
         q_o = shf_v[15:0];
      end else if (shf_v[ACC_W]) begin
         q_o = SAT16_MIN;
      end else begin
         q_o = SAT16_MAX;
      end
   end

endmodule

// File: rtl/psmac_accum.sv
// Group accumulator behind the MAC array with a one-entry valid/ready result buffer.
module psmac_accum
   import psmac_pkg::*;
#(
   parameter int unsigned ACC_W   = ACC_W_DEF,
   parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [15:0]                  in_data,
   input  logic                         in_last,
   output logic                         in_ready,
   input  logic                         relu_en,
   input  logic [3:0]                   shamt,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_W-1:0]             out_raw,
   output logic [15:0]                  out_q,
   output logic [$clog2(MAX_LEN+1)-1:0] out_len,
   output logic                         out_ovf
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN+1);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic             buf_valid_q, buf_valid_d;
   logic [ACC_W-1:0] buf_raw_q, buf_raw_d;
   logic [15:0]      buf_q16_q, buf_q16_d;
   logic [CNT_W-1:0] buf_len_q, buf_len_d;
   logic             buf_ovf_q, buf_ovf_d;

   logic [ACC_W:0]   base_w;
   logic [ACC_W:0]   sum_w;
   logic             sat_hit_w;
   logic [ACC_W-1:0] sum_sat_w;
   logic             accept_w;
   logic             closing_w;
   logic [15:0]      rq_w;

   assign in_ready  = !buf_valid_q || out_ready;
   assign accept_w  = in_valid && in_ready;
   assign closing_w = in_last || (cnt_q == CNT_W'(MAX_LEN - 1));

   // Widened add, then clamp to the signed ACC_W range.
   always_comb begin
      base_w    = (state_q == S_IDLE) ? '0 : {acc_q[ACC_W-1], acc_q};
      sum_w     = base_w + {{(ACC_W-15){in_data[15]}}, in_data};
      sat_hit_w = sum_w[ACC_W] ^ sum_w[ACC_W-1];
      if (!sat_hit_w) begin
         sum_sat_w = sum_w[ACC_W-1:0];
      end else if (sum_w[ACC_W]) begin
         sum_sat_w = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
         sum_sat_w = {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   psmac_requant #(.ACC_W(ACC_W)) u_requant (
      .val_i     (sum_sat_w),
      .relu_en_i (relu_en),
      .shamt_i   (shamt),
      .q_o       (rq_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_raw_q   <= '0;
         buf_q16_q   <= '0;
         buf_len_q   <= '0;
         buf_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         buf_valid_q <= buf_valid_d;
         buf_raw_q   <= buf_raw_d;
         buf_q16_q   <= buf_q16_d;
         buf_len_q   <= buf_len_d;
         buf_ovf_q   <= buf_ovf_d;
      end
   end

   // A closing beat reloads the buffer even while it drains, so no bubble.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      buf_valid_d = buf_valid_q;
      buf_raw_d   = buf_raw_q;
      buf_q16_d   = buf_q16_q;
      buf_len_d   = buf_len_q;
      buf_ovf_d   = buf_ovf_q;

      if (buf_valid_q && out_ready) begin
         buf_valid_d = 1'b0;
      end

      if (accept_w) begin
         if (closing_w) begin
            buf_valid_d = 1'b1;
            buf_raw_d   = sum_sat_w;
            buf_q16_d   = rq_w;
            buf_len_d   = cnt_q + CNT_W'(1);
            buf_ovf_d   = ovf_q | sat_hit_w;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = S_IDLE;
         end else begin
            acc_d       = sum_sat_w;
            cnt_d       = cnt_q + CNT_W'(1);
            ovf_d       = ovf_q | sat_hit_w;
            state_d     = S_ACC;
         end
      end
   end

   assign out_valid = buf_valid_q;
   assign out_raw   = buf_raw_q;
   assign out_q     = buf_q16_q;
   assign out_len   = buf_len_q;
   assign out_ovf   = buf_ovf_q;

endmodule

// File: tb/tb_psmac_accum.sv
// Scoreboard bench for psmac_accum: a 32-bit/MAX_LEN=8 instance plus a 24-bit saturation instance.
module tb_psmac_accum;

   localparam int unsigned AW  = 32;
   localparam int unsigned ML  = 8;
   localparam int unsigned LW  = $clog2(ML+1);
   localparam int unsigned AW2 = 24;
   localparam int unsigned ML2 = 1024;
   localparam int unsigned LW2 = $clog2(ML2+1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          in_valid, in_last, in_ready, relu_en, out_valid, out_ready, out_ovf;
   logic [15:0]   in_data, out_q;
   logic [3:0]    shamt;
   logic [AW-1:0] out_raw;
   logic [LW-1:0] out_len;

   logic           in_valid2, in_last2, in_ready2, out_valid2, out_ovf2;
   logic [15:0]    in_data2, out_q2;
   logic [AW2-1:0] out_raw2;
   logic [LW2-1:0] out_len2;

   psmac_accum #(.ACC_W(AW), .MAX_LEN(ML)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .relu_en(relu_en), .shamt(shamt), .out_valid(out_valid),
      .out_ready(out_ready), .out_raw(out_raw), .out_q(out_q), .out_len(out_len), .out_ovf(out_ovf)
   );

   psmac_accum #(.ACC_W(AW2), .MAX_LEN(ML2)) dut24 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_last(in_last2),
      .in_ready(in_ready2), .relu_en(1'b0), .shamt(4'd0), .out_valid(out_valid2),
      .out_ready(1'b1), .out_raw(out_raw2), .out_q(out_q2), .out_len(out_len2), .out_ovf(out_ovf2)
   );

   typedef struct {
      longint raw;
      longint q;
      longint len;
      longint ovf;
   } exp_t;

   exp_t   sb[$];
   int     n_chk  = 0;
   int     n_fail = 0;
   longint m_acc  = 0;
   int     m_cnt  = 0;
   bit     m_ovf  = 1'b0;
   bit     rnd_on = 1'b0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic longint clampw(input longint v, input int w, output bit hit);
      longint hi = (64'sd1 <<< (w - 1)) - 1;
      longint lo = -(64'sd1 <<< (w - 1));
      hit = 1'b0;
      if (v > hi) begin hit = 1'b1; return hi; end
      if (v < lo) begin hit = 1'b1; return lo; end
      return v;
   endfunction

   function automatic longint requant(input longint v, input bit relu, input int sh);
      longint r = v;
      bit     dummy;
      if (relu && r < 0) r = 0;
      if (sh > 0) r = r + (64'sd1 <<< (sh - 1));
      r = r >>> sh;
      return clampw(r, 16, dummy);
   endfunction

   // Drive one beat, wait for acceptance, then advance the reference model.
   task automatic send_beat(input longint d, input bit last, input bit relu = 1'b0, input int sh = 0);
      bit     ok = 1'b0;
      bit     hit;
      longint s;
      in_valid = 1'b1;
      in_data  = 16'(d);
      in_last  = last;
      relu_en  = relu;
      shamt    = 4'(sh);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!ok) begin
         chk("beat_timeout", 0, 1);
      end else begin
         s     = clampw(m_acc + d, AW, hit);
         m_ovf = m_ovf | hit;
         m_cnt++;
         if (last || m_cnt == ML) begin
            sb.push_back('{raw: s, q: requant(s, relu, sh), len: m_cnt, ovf: longint'(m_ovf)});
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
         end else begin
            m_acc = s;
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk("sb_drain", sb.size(), 0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("out_raw", longint'($signed(out_raw)), e.raw);
            chk("out_q",   longint'($signed(out_q)),   e.q);
            chk("out_len", longint'(out_len),          e.len);
            chk("out_ovf", longint'(out_ovf),          e.ovf);
         end
      end
   end

   initial begin
      logic signed [15:0] rd;
      longint e24;
      bit     h24;
      bit     ovf24;
      int     glen;

      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; relu_en = 1'b0; shamt = '0; out_ready = 1'b1;
      in_valid2 = 1'b0; in_data2 = '0; in_last2 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_raw",   longint'(out_raw),   0);
      chk("rst_out_q",     longint'(out_q),     0);
      chk("rst_out_len",   longint'(out_len),   0);
      chk("rst_out_ovf",   longint'(out_ovf),   0);
      chk("rst_in_ready",  longint'(in_ready),  1);
      @(posedge clk); #1;

      // Basic sum and one-cycle latency.
      send_beat(100, 0); send_beat(-30, 0); send_beat(7, 0); send_beat(1000, 1);
      chk("latency_valid", longint'(out_valid), 1);
      chk("latency_raw",   longint'($signed(out_raw)), 1077);

      // Requantisation and 16-bit saturation.
      send_beat(-5, 1, 1'b1, 0);
      send_beat(32767, 1, 1'b0, 4);
      send_beat(32767, 0); send_beat(32767, 0); send_beat(32767, 1);
      drain();

      // Forced close at MAX_LEN.
      for (int i = 1; i <= 10; i++) send_beat(1, i == 10);
      drain();

      // Backpressure: pending result stalls the next group.
      out_ready = 1'b0;
      send_beat(10, 1);
      fork
         begin send_beat(3, 0); send_beat(4, 1); end
      join_none
      repeat (3) @(negedge clk);
      chk("bp_in_ready",  longint'(in_ready),  0);
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_hold_raw",  longint'($signed(out_raw)), 10);
      @(posedge clk); #1 out_ready = 1'b1;
      wait fork;
      drain();

      // Reset mid-group discards the partial sum.
      send_beat(1, 0); send_beat(2, 0); send_beat(3, 0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      send_beat(5, 1);
      drain();

      // Random groups under random backpressure, including back-to-back length-1 groups.
      rnd_on = 1'b1;
      fork
         begin
            while (rnd_on) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      for (int g = 0; g < 25; g++) begin
         glen = $urandom_range(1, 5);
         for (int b = 0; b < glen; b++) begin
            rd = 16'($urandom);
            send_beat(longint'(rd), b == glen - 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
         end
      end
      rnd_on = 1'b0;
      repeat (2) @(posedge clk);
      #2 out_ready = 1'b1;
      drain();

      // 24-bit accumulator saturates over 512 full-scale beats.
      e24 = 0; ovf24 = 1'b0;
      for (int i = 0; i < 512; i++) begin
         e24   = clampw(e24 + 32767, AW2, h24);
         ovf24 = ovf24 | h24;
         in_valid2 = 1'b1; in_data2 = 16'h7FFF; in_last2 = (i == 511);
         @(posedge clk); #1;
      end
      in_valid2 = 1'b0; in_last2 = 1'b0;
      @(negedge clk);
      chk("w24_valid", longint'(out_valid2), 1);
      chk("w24_raw",   longint'($signed(out_raw2)), e24);
      chk("w24_ovf",   longint'(out_ovf2), longint'(ovf24));
      chk("w24_len",   longint'(out_len2), 512);
      chk("w24_q",     longint'($signed(out_q2)), requant(e24, 1'b0, 0));
      chk("w24_ready", longint'(in_ready2), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
